mnist_mac_engine: RTL and testbench
===================================

Name: mnist_mac_engine

Overview:
- Hardware dot-product stage directly downstream of the NIOS PIO exports in the MNIST classifier system.
- Consumes sync_data, floatdata_output, pixel_index and activations_index. Produces the 32-bit word read back through results_input.
- Software loads a 784-pixel image, streams weights per output neuron, then reads back 10 activations.
- Operands are signed Q16.16 fixed point; software converts float to Q16.16 before writing.

Parameters:
- PIX_DEPTH, 784, valid pixel entries (RAM is 1024 deep)
- N_ACT, 10, number of activation registers
- DATA_W, 32, operand/result width
- FRAC_W, 16, fractional bits of operands
- ACC_W, 48, accumulator width

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- cmd_word  in  16  [15] toggle strobe, [14:12] opcode, [11:0] reserved (ignored)
- operand  in  32  Q16.16 pixel, weight or bias
- pixel_index  in  10  pixel RAM address
- activations_index  in  4  activation register select
- results  out  32  status word or activation value, selected by read view

Behaviour:
- Reset: results = status view with all bits zero. acc=0, act[]=0, accepted_toggle=0, ack_toggle=0, busy=0, ovf=0, mac_count=0, view=STATUS. RAM contents are undefined.
- Command detect: a command is accepted on the first edge where cmd_word[15] != accepted_toggle and busy=0. That edge also latches opcode, operand and both indices, and sets accepted_toggle := cmd_word[15].
- A toggle change while busy=1 is not lost. It is level-compared and accepted on the first idle edge.
- Opcodes (accept edge N):
  - 0 NOP: ack at N+1.
  - 1 WR_PIX: pix[pixel_index] := operand at N+1. Writes with index >= PIX_DEPTH are ignored.
  - 2 CLR: acc := 0, ovf := 0, mac_count := 0 at N+1.
  - 3 MAC: RAM read issued at N, data at N+1. Product is registered at N+2: the 64-bit signed product, bits [47:16], sign-extended. acc += product at N+3, mac_count += 1 (wraps at 16 bits). busy stays 1 from N through N+3. Pixel index >= PIX_DEPTH reads as 0.
  - 4 BIAS: acc += sign-extended operand at N+1.
  - 5 STORE: act[activations_index] := sat32(acc) at N+1. If acc exceeds the 32-bit signed range, clamp to 0x7FFFFFFF/0x80000000 and set ovf. Index >= N_ACT is ignored.
  - 6 RD_ACT: view := ACT, rd_sel := activations_index at N+1. results shows act[rd_sel]; index >= N_ACT reads 0.
  - 7 RD_STAT: view := STATUS at N+1.
- Accumulator add saturates at ACC_W signed bounds and sets ovf (sticky until CLR).
- Completion: ack_toggle := accepted_toggle and busy := 0 on the completion edge (N+1, or N+3 for MAC).
- Status view is live and combinational from registers: [31] ack_toggle, [30] busy, [29] ovf, [28:16] 0, [15:0] mac_count.
- Software contract: after a RD_ACT, return to the status view with RD_STAT before polling.
- Reset asserted mid-MAC aborts the pipeline immediately. No partial accumulate and no ack occurs.

Optional Feature:
- Macro: MNIST_MAC_RELU_EN.
- Defined: STORE writes max(sat32(acc), 0); negative results store 0x00000000.
- Undefined: STORE writes the signed sat32(acc) unchanged. All other behaviour is identical.

Decomposition:
- Package mnist_mac_pkg:
  - opcode enum (NOP, WR_PIX, CLR, MAC, BIAS, STORE, RD_ACT, RD_STAT)
  - status bit positions
  - DATA_W/FRAC_W/ACC_W constants
  - view enum
- One sub-module, mnist_pixel_ram: 1024x32, one synchronous write port, one synchronous read port, read latency 1, no reset.

Test Plan:
- Reset, then no command -> results=0x00000000; toggle 0->1 with NOP -> results[31]=1 one cycle after accept, busy never visible high to the bench after completion.
- WR_PIX pix[5]=0x00020000 (2.0); CLR; MAC operand=0x00018000 (1.5), index 5 -> acc=0x30000 at accept+3. STORE act[0] -> RD_ACT 0 -> results=0x00030000; mac_count=1.
- Toggle flipped again while a MAC is busy -> second command accepted at accept+4, not dropped. Two acks observed in order.
- BIAS 0x7FFFFFFF twice, then STORE act[1] -> act[1]=0x7FFFFFFF, status[29]=1. CLR -> status[29]=0, mac_count=0.
- acc=-3.0 (0xFFFD0000), STORE act[2] -> RD_ACT gives 0x00000000 with MNIST_MAC_RELU_EN, 0xFFFD0000 without.
- Out-of-range cases: WR_PIX index 900 ignored and MAC index 900 adds 0; STORE/RD_ACT index 12 ignored/returns 0. reset_n low at MAC accept+2 -> all registers zero, no ack.

Source files
------------

// File: rtl/mnist_mac_pkg.sv
// Shared types, widths and saturation helpers for the MNIST dot-product engine.
package mnist_mac_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned ACC_W    = 48;
  localparam int unsigned RAM_DEPTH = 1024;

  localparam int unsigned StatAckBit  = 31;
  localparam int unsigned StatBusyBit = 30;
  localparam int unsigned StatOvfBit  = 29;

  typedef enum logic [2:0] {
    OpNop, OpWrPix, OpClr, OpMac, OpBias, OpStore, OpRdAct, OpRdStat
  } opcode_e;

  typedef enum logic {ViewStatus, ViewAct} view_e;

  // Returns {overflow, sum} with the sum clamped to the signed ACC_W range.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}} : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Returns {overflow, value} with the value clamped to the signed DATA_W range.
  function automatic logic [DATA_W:0] sat32(input logic [ACC_W-1:0] a);
    logic [ACC_W-DATA_W:0] top;
    top = a[ACC_W-1:DATA_W-1];
    if ((&top) || !(|top)) return {1'b0, a[DATA_W-1:0]};
    return a[ACC_W-1] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
  endfunction

endpackage

// File: rtl/mnist_mac_engine_if.sv
// Command/operand/result bundle between the PIO exports and the MAC engine.
interface mnist_mac_engine_if;
  import mnist_mac_pkg::*;

  logic [15:0]       cmd_word;
  logic [DATA_W-1:0] operand;
  logic [9:0]        pixel_index;
  logic [3:0]        activations_index;
  logic [DATA_W-1:0] results;

  modport master (output cmd_word, operand, pixel_index, activations_index, input results);
  modport slave  (input cmd_word, operand, pixel_index, activations_index, output results);
endinterface

// File: rtl/mnist_pixel_ram.sv
// Simple dual-port pixel store: one synchronous write, one synchronous read, no reset.
module mnist_pixel_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/mnist_mac_engine.sv
// Toggle-strobed Q16.16 dot-product engine with activation registers.
// Optional ReLU on STORE when MNIST_MAC_RELU_EN is defined.
module mnist_mac_engine
  import mnist_mac_pkg::*;
#(
  parameter int unsigned PIX_DEPTH = 784,
  parameter int unsigned N_ACT     = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  mnist_mac_engine_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StExec, StMacRd, StMacMul, StMacAcc} state_e;

  localparam logic [9:0] PixLimit = 10'(PIX_DEPTH);
  localparam logic [3:0] ActLimit = 4'(N_ACT);

  state_e            state_q, state_d;
  opcode_e           op_q, op_d;
  view_e             view_q, view_d;
  logic              accepted_toggle_q, accepted_toggle_d;
  logic              ack_toggle_q, ack_toggle_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       mac_count_q, mac_count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  prod_q, prod_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [9:0]        pix_idx_q, pix_idx_d;
  logic [3:0]        act_idx_q, act_idx_d;
  logic [3:0]        rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] act_q [N_ACT];
  logic [DATA_W-1:0] act_d [N_ACT];

  logic              busy, accept;
  logic [DATA_W-1:0] ram_rdata, store_word;
  logic signed [63:0] prod_full;
  logic [ACC_W:0]    bias_sum, mac_sum;
  logic [DATA_W:0]   store_sat;
  logic              unused_bits;

  assign busy   = (state_q != StIdle);
  assign accept = (bus.cmd_word[15] != accepted_toggle_q) && !busy;

  mnist_pixel_ram #(
    .Depth (RAM_DEPTH),
    .Width (DATA_W)
  ) u_pixel_ram (
    .clk_i   (clk),
    .we_i    ((state_q == StExec) && (op_q == OpWrPix) && (pix_idx_q < PixLimit)),
    .waddr_i (pix_idx_q),
    .wdata_i (operand_q),
    .raddr_i (bus.pixel_index),
    .rdata_o (ram_rdata)
  );

  assign prod_full = $signed(mul_a_q) * $signed(operand_q);
  assign bias_sum  = sat_add(acc_q, {{(ACC_W-DATA_W){operand_q[DATA_W-1]}}, operand_q});
  assign mac_sum   = sat_add(acc_q, prod_q);
  assign store_sat = sat32(acc_q);
`ifdef MNIST_MAC_RELU_EN
  assign store_word = store_sat[DATA_W-1] ? '0 : store_sat[DATA_W-1:0];
`else
  assign store_word = store_sat[DATA_W-1:0];
`endif
  assign unused_bits = ^{bus.cmd_word[11:0], prod_full[63:48], prod_full[FRAC_W-1:0]};

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    view_d            = view_q;
    accepted_toggle_d = accepted_toggle_q;
    ack_toggle_d      = ack_toggle_q;
    ovf_d             = ovf_q;
    mac_count_d       = mac_count_q;
    acc_d             = acc_q;
    prod_d            = prod_q;
    mul_a_d           = mul_a_q;
    operand_d         = operand_q;
    pix_idx_d         = pix_idx_q;
    act_idx_d         = act_idx_q;
    rd_sel_d          = rd_sel_q;
    act_d             = act_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          accepted_toggle_d = bus.cmd_word[15];
          op_d              = opcode_e'(bus.cmd_word[14:12]);
          operand_d         = bus.operand;
          pix_idx_d         = bus.pixel_index;
          act_idx_d         = bus.activations_index;
          state_d           = (opcode_e'(bus.cmd_word[14:12]) == OpMac) ? StMacRd : StExec;
        end
      end
      StExec: begin
        case (op_q)
          OpClr: begin
            acc_d       = '0;
            ovf_d       = 1'b0;
            mac_count_d = '0;
          end
          OpBias: begin
            acc_d = bias_sum[ACC_W-1:0];
            if (bias_sum[ACC_W]) ovf_d = 1'b1;
          end
          OpStore: begin
            if (act_idx_q < ActLimit) act_d[act_idx_q] = store_word;
            if (store_sat[DATA_W]) ovf_d = 1'b1;
          end
          OpRdAct: begin
            view_d   = ViewAct;
            rd_sel_d = act_idx_q;
          end
          OpRdStat: view_d = ViewStatus;
          default: ;
        endcase
        ack_toggle_d = accepted_toggle_q;
        state_d      = StIdle;
      end
      // RAM data for the address sampled on the accept edge is valid here.
      StMacRd: begin
        mul_a_d = (pix_idx_q < PixLimit) ? ram_rdata : '0;
        state_d = StMacMul;
      end
      StMacMul: begin
        prod_d  = {{(ACC_W-DATA_W){prod_full[47]}}, prod_full[47:16]};
        state_d = StMacAcc;
      end
      StMacAcc: begin
        acc_d        = mac_sum[ACC_W-1:0];
        if (mac_sum[ACC_W]) ovf_d = 1'b1;
        mac_count_d  = mac_count_q + 16'd1;
        ack_toggle_d = accepted_toggle_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      op_q              <= OpNop;
      view_q            <= ViewStatus;
      accepted_toggle_q <= 1'b0;
      ack_toggle_q      <= 1'b0;
      ovf_q             <= 1'b0;
      mac_count_q       <= '0;
      acc_q             <= '0;
      prod_q            <= '0;
      mul_a_q           <= '0;
      operand_q         <= '0;
      pix_idx_q         <= '0;
      act_idx_q         <= '0;
      rd_sel_q          <= '0;
      for (int i = 0; i < int'(N_ACT); i++) act_q[i] <= '0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_d;
      view_q            <= view_d;
      accepted_toggle_q <= accepted_toggle_d;
      ack_toggle_q      <= ack_toggle_d;
      ovf_q             <= ovf_d;
      mac_count_q       <= mac_count_d;
      acc_q             <= acc_d;
      prod_q            <= prod_d;
      mul_a_q           <= mul_a_d;
      operand_q         <= operand_d;
      pix_idx_q         <= pix_idx_d;
      act_idx_q         <= act_idx_d;
      rd_sel_q          <= rd_sel_d;
      act_q             <= act_d;
    end
  end

  always_comb begin
    bus.results = '0;
    if (view_q == ViewAct) begin
      if (rd_sel_q < ActLimit) bus.results = act_q[rd_sel_q];
    end else begin
      bus.results[StatAckBit]  = ack_toggle_q;
      bus.results[StatBusyBit] = busy;
      bus.results[StatOvfBit]  = ovf_q;
      bus.results[15:0]        = mac_count_q;
    end
  end

endmodule

// File: tb/tb_mnist_mac_engine.sv
// Directed bench for mnist_mac_engine; expected values are hand-computed Q16.16 results.
module tb_mnist_mac_engine;
  import mnist_mac_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic tog = 1'b0;
  logic t1;
  int   n_chk = 0;
  int   n_fail = 0;

  mnist_mac_engine_if bus ();

  mnist_mac_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic ack, input logic bsy, input logic ovf,
                                       input logic [15:0] mc);
    return {ack, bsy, ovf, 13'h0, mc};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic drive(input opcode_e op, input logic [31:0] opnd, input logic [9:0] pix,
                       input logic [3:0] ai);
    tog                   = ~tog;
    bus.cmd_word          = {tog, op, 12'h000};
    bus.operand           = opnd;
    bus.pixel_index       = pix;
    bus.activations_index = ai;
  endtask

  task automatic send(input opcode_e op, input logic [31:0] opnd, input logic [9:0] pix,
                      input logic [3:0] ai);
    drive(op, opnd, pix, ai);
    tick((op == OpMac) ? 4 : 2);
  endtask

  initial begin
    bus.cmd_word          = '0;
    bus.operand           = '0;
    bus.pixel_index       = '0;
    bus.activations_index = '0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("reset", bus.results, 32'h0000_0000);

    drive(OpNop, 32'h0, 10'd0, 4'd0);
    tick(1);
    chk("nop_busy", bus.results, stat(1'b0, 1'b1, 1'b0, 16'd0));
    tick(1);
    chk("nop_ack", bus.results, stat(1'b1, 1'b0, 1'b0, 16'd0));

    // 2.0 * 1.5 = 3.0
    send(OpWrPix, 32'h0002_0000, 10'd5, 4'd0);
    send(OpClr, 32'h0, 10'd0, 4'd0);
    drive(OpMac, 32'h0001_8000, 10'd5, 4'd0);
    tick(3);
    chk("mac_busy_n2", bus.results, stat(~tog, 1'b1, 1'b0, 16'd0));
    tick(1);
    chk("mac_done_n3", bus.results, stat(tog, 1'b0, 1'b0, 16'd1));
    send(OpStore, 32'h0, 10'd0, 4'd0);
    send(OpRdAct, 32'h0, 10'd0, 4'd0);
    chk("act0", bus.results, 32'h0003_0000);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);
    chk("stat_count1", bus.results, stat(tog, 1'b0, 1'b0, 16'd1));

    // Toggle flipped while MAC is busy: NOP must be accepted at N+4.
    drive(OpMac, 32'h0001_0000, 10'd5, 4'd0);
    tick(2);
    t1 = tog;
    drive(OpNop, 32'h0, 10'd0, 4'd0);
    tick(2);
    chk("ovl_mac_ack", bus.results, stat(t1, 1'b0, 1'b0, 16'd2));
    tick(1);
    chk("ovl_nop_busy", bus.results, stat(t1, 1'b1, 1'b0, 16'd2));
    tick(1);
    chk("ovl_nop_ack", bus.results, stat(~t1, 1'b0, 1'b0, 16'd2));
    send(OpStore, 32'h0, 10'd0, 4'd4);
    send(OpRdAct, 32'h0, 10'd0, 4'd4);
    chk("act4_acc5", bus.results, 32'h0005_0000);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);

    // Store saturation.
    send(OpClr, 32'h0, 10'd0, 4'd0);
    send(OpBias, 32'h7FFF_FFFF, 10'd0, 4'd0);
    send(OpBias, 32'h7FFF_FFFF, 10'd0, 4'd0);
    send(OpStore, 32'h0, 10'd0, 4'd1);
    chk("sat_ovf", bus.results, stat(tog, 1'b0, 1'b1, 16'd0));
    send(OpRdAct, 32'h0, 10'd0, 4'd1);
    chk("act1_sat", bus.results, 32'h7FFF_FFFF);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);
    send(OpClr, 32'h0, 10'd0, 4'd0);
    chk("clr_ovf", bus.results, stat(tog, 1'b0, 1'b0, 16'd0));

    // -3.0 through STORE.
    send(OpBias, 32'hFFFD_0000, 10'd0, 4'd0);
    send(OpStore, 32'h0, 10'd0, 4'd2);
    send(OpRdAct, 32'h0, 10'd0, 4'd2);
`ifdef MNIST_MAC_RELU_EN
    chk("act2_neg", bus.results, 32'h0000_0000);
`else
    chk("act2_neg", bus.results, 32'hFFFD_0000);
`endif
    send(OpRdStat, 32'h0, 10'd0, 4'd0);

    // Out-of-range indices.
    send(OpClr, 32'h0, 10'd0, 4'd0);
    send(OpWrPix, 32'h0001_0000, 10'd900, 4'd0);
    send(OpBias, 32'h0001_0000, 10'd0, 4'd0);
    send(OpMac, 32'h0001_0000, 10'd900, 4'd0);
    send(OpStore, 32'h0, 10'd0, 4'd3);
    send(OpRdAct, 32'h0, 10'd0, 4'd3);
    chk("mac_oor_adds0", bus.results, 32'h0001_0000);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);
    chk("oor_count", bus.results, stat(tog, 1'b0, 1'b0, 16'd1));
    send(OpStore, 32'h0, 10'd0, 4'd12);
    send(OpRdAct, 32'h0, 10'd0, 4'd12);
    chk("rd_act12", bus.results, 32'h0000_0000);
    send(OpRdAct, 32'h0, 10'd0, 4'd0);
    chk("act0_intact", bus.results, 32'h0003_0000);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);

    // Reset during MAC at accept+2.
    drive(OpMac, 32'h0001_0000, 10'd5, 4'd0);
    tick(2);
    reset_n      = 1'b0;
    tog          = 1'b0;
    bus.cmd_word = '0;
    #1;
    chk("rst_mid", bus.results, 32'h0000_0000);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    chk("rst_no_ack", bus.results, 32'h0000_0000);
    send(OpRdAct, 32'h0, 10'd0, 4'd0);
    chk("rst_act0", bus.results, 32'h0000_0000);
    send(OpStore, 32'h0, 10'd0, 4'd5);
    send(OpRdAct, 32'h0, 10'd0, 4'd5);
    chk("rst_acc0", bus.results, 32'h0000_0000);
    send(OpRdStat, 32'h0, 10'd0, 4'd0);
    chk("rst_stat", bus.results, stat(tog, 1'b0, 1'b0, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
